// File: rtl/instr_loader_pkg.sv
// Shared constants and FSM encoding for the serial instruction loader.
package instr_loader_pkg;

  localparam int unsigned WORD_W_DEF = 9;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for assembled instruction words; full/empty come from count only.
module instr_fifo #(
  parameter int unsigned WORD_W = 9,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       SCLR,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WORD_W-1:0]          din,
  output logic [WORD_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign rd_ok = pop && (count != '0);
  assign wr_ok = push && ((count != FULL_CNT) || rd_ok);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (SCLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (!wr_ok && rd_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok && !SCLR) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_loader.sv
// Serial-to-parallel instruction loader feeding the accumulator core via a small FIFO.
// Build option: define INSTR_LOADER_PARITY_EN for an even-parity bit after each word.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       SDATA,
  input  logic                       SVALID,
  input  logic                       SCLR,
  input  logic                       OUT_READY,
  output logic [WORD_W-1:0]          INSTRUCTION,
  output logic                       WRITE_EN,
  output logic [$clog2(DEPTH+1)-1:0] FIFO_COUNT,
  output logic                       OVERFLOW,
  output logic                       PARITY_ERR
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);
`ifdef INSTR_LOADER_PARITY_EN
  localparam int unsigned SH_W = WORD_W;
`else
  localparam int unsigned SH_W = WORD_W - 1;
`endif

  state_t                state, state_n;
  logic [BIT_CNT_W-1:0]  bit_cnt, cnt_n;
  logic [SH_W-1:0]       shift, shift_n;
  logic [WORD_W-1:0]     word_in;
  logic [WORD_W-1:0]     fifo_din;
  logic [WORD_W-1:0]     fifo_dout;
  logic                  push;
  logic                  pop;
  logic                  full;
`ifdef INSTR_LOADER_PARITY_EN
  logic                  parity_bad;
`endif

  assign word_in = {shift[WORD_W-2:0], SDATA};
  assign pop     = OUT_READY && (FIFO_COUNT != '0);
  assign full    = (FIFO_COUNT == FULL_CNT);

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    shift_n = shift;
    push    = 1'b0;
`ifdef INSTR_LOADER_PARITY_EN
    parity_bad = 1'b0;
`endif
    if (SVALID) begin
      case (state)
        IDLE: begin
          shift_n    = '0;
          shift_n[0] = SDATA;
          cnt_n      = BIT_CNT_W'(1);
          state_n    = SHIFT;
        end
        SHIFT: begin
          shift_n = word_in[SH_W-1:0];
          if (bit_cnt == LAST_BIT) begin
`ifdef INSTR_LOADER_PARITY_EN
            cnt_n   = bit_cnt + BIT_CNT_W'(1);
            state_n = PARITY;
`else
            push    = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
`endif
          end else begin
            cnt_n = bit_cnt + BIT_CNT_W'(1);
          end
        end
`ifdef INSTR_LOADER_PARITY_EN
        PARITY: begin
          cnt_n   = '0;
          state_n = IDLE;
          if (^{shift, SDATA}) parity_bad = 1'b1;
          else                 push       = 1'b1;
        end
`endif
        default: begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_LOADER_PARITY_EN
  assign fifo_din = shift;
`else
  assign fifo_din = word_in;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (SCLR) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shift   <= shift_n;
    end
  end

  instr_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .SCLR    (SCLR),
    .push    (push),
    .pop     (pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .count   (FIFO_COUNT)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      INSTRUCTION <= '0;
      WRITE_EN    <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else if (SCLR) begin
      INSTRUCTION <= '0;
      WRITE_EN    <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      WRITE_EN <= pop;
      if (pop) INSTRUCTION <= fifo_dout;
      if (push && full && !pop) OVERFLOW <= 1'b1;
    end
  end

`ifdef INSTR_LOADER_PARITY_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)        PARITY_ERR <= 1'b0;
    else if (SCLR)       PARITY_ERR <= 1'b0;
    else if (parity_bad) PARITY_ERR <= 1'b1;
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: queue-based frame/FIFO model plus directed scenarios.
module tb_instr_loader;

  localparam int W = 9;
  localparam int D = 4;
`ifdef INSTR_LOADER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b1;
  logic         SDATA = 1'b0;
  logic         SVALID = 1'b0;
  logic         SCLR = 1'b0;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] INSTRUCTION;
  logic         WRITE_EN;
  logic [2:0]   FIFO_COUNT;
  logic         OVERFLOW;
  logic         PARITY_ERR;

  instr_loader #(
    .WORD_W (W),
    .DEPTH  (D)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .SDATA       (SDATA),
    .SVALID      (SVALID),
    .SCLR        (SCLR),
    .OUT_READY   (OUT_READY),
    .INSTRUCTION (INSTRUCTION),
    .WRITE_EN    (WRITE_EN),
    .FIFO_COUNT  (FIFO_COUNT),
    .OVERFLOW    (OVERFLOW),
    .PARITY_ERR  (PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bits collect into frames; words live in a bounded queue.
  bit           mbits[$];
  logic [W-1:0] mq[$];
  logic         m_we;
  logic [W-1:0] m_instr;
  bit           m_ovf;
  bit           m_perr;
  int           m_pre;
  bit           m_pop;
  bit           m_have;
  logic [W-1:0] m_w;
  int           m_ones;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N || SCLR) begin
      mbits.delete();
      mq.delete();
      m_we = 1'b0;
      m_instr = '0;
      m_ovf = 1'b0;
      m_perr = 1'b0;
    end else begin
      m_pre  = mq.size();
      m_pop  = OUT_READY && (m_pre > 0);
      m_have = 1'b0;
      if (SVALID) begin
        mbits.push_back(SDATA);
        if (mbits.size() == FRAME) begin
          m_w = '0;
          m_ones = 0;
          for (int i = 0; i < FRAME; i++) if (mbits[i]) m_ones++;
          for (int i = 0; i < W; i++) m_w = {m_w[W-2:0], mbits[i]};
          if (FRAME == W || (m_ones % 2) == 0) m_have = 1'b1;
          else m_perr = 1'b1;
          mbits.delete();
        end
      end
      if (m_pop) begin
        m_instr = mq.pop_front();
        m_we = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (m_have) begin
        if (m_pre < D || m_pop) mq.push_back(m_w);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(posedge CLK) cyc++;

  logic [W-1:0] out_w[$];
  int           out_c[$];

  always @(negedge CLK) begin
    if (chk_en) begin
      check("write_en", WRITE_EN, m_we);
      check("instruction", INSTRUCTION, m_instr);
      check("fifo_count", FIFO_COUNT, mq.size());
      check("overflow", OVERFLOW, m_ovf);
      check("parity_err", PARITY_ERR, m_perr);
      if (WRITE_EN) begin
        out_w.push_back(INSTRUCTION);
        out_c.push_back(cyc);
      end
    end
  end

  // Main process acts 1ns after each falling edge, after the compare process has run.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit p, input bit gap,
                            input bit raise_last, output int last_edge);
    logic [FRAME-1:0] f;
`ifdef INSTR_LOADER_PARITY_EN
    f = {w, p};
`else
    f = w;
    if (p) f = w;
`endif
    for (int i = FRAME - 1; i >= 0; i--) begin
      if (i == 0 && raise_last) OUT_READY = 1'b1;
      SVALID = 1'b1;
      SDATA  = f[i];
      tick();
      if (gap && i != 0) begin
        SVALID = 1'b0;
        SDATA  = ~SDATA;
        tick();
      end
    end
    SVALID = 1'b0;
    last_edge = cyc;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gap);
    int e;
    send_frame(w, ^w, gap, 1'b0, e);
  endtask

  int e1, e2, mark;
  logic [W-1:0] k9;

  initial begin
    #1 RESET_N = 1'b0;
    #2;
    check("rst_instr", INSTRUCTION, 0);
    check("rst_we", WRITE_EN, 0);
    check("rst_count", FIFO_COUNT, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_perr", PARITY_ERR, 0);
    chk_en = 1'b1;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // Reset mid-word
    OUT_READY = 1'b1;
    send_word(9'h0C3, 1'b0);
    repeat (3) tick();
    OUT_READY = 1'b0;
    send_word(9'h055, 1'b0);
    tick();
    check("t1_pre_instr", INSTRUCTION, 9'h0C3);
    check("t1_pre_count", FIFO_COUNT, 1);
    for (int i = 0; i < 5; i++) begin
      SVALID = 1'b1;
      SDATA  = i[0];
      tick();
    end
    SVALID = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    check("t1_async_instr", INSTRUCTION, 0);
    check("t1_async_count", FIFO_COUNT, 0);
    check("t1_async_we", WRITE_EN, 0);
    check("t1_async_ovf", OVERFLOW, 0);
    tick();
    RESET_N = 1'b1;
    tick();
    mark = out_w.size();
    OUT_READY = 1'b1;
    send_word(9'h1A5, 1'b0);
    repeat (4) tick();
    check("t1_pulses", out_w.size() - mark, 1);
    if (out_w.size() > mark) check("t1_word", out_w[mark], 9'h1A5);

    // Back-to-back words with SVALID gaps
    mark = out_w.size();
    send_frame(9'h001, ^(9'h001), 1'b1, 1'b0, e1);
    send_frame(9'h1FF, ^(9'h1FF), 1'b1, 1'b0, e2);
    repeat (4) tick();
    check("t2_pulses", out_w.size() - mark, 2);
    if (out_w.size() >= mark + 2) begin
      check("t2_word0", out_w[mark], 9'h001);
      check("t2_word1", out_w[mark+1], 9'h1FF);
      check("t2_lat0", out_c[mark], e1 + 1);
      check("t2_lat1", out_c[mark+1], e2 + 1);
    end

    // Overflow with consumer stalled
    OUT_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      k9 = 9'h010 + 9'(k);
      send_word(k9, 1'b0);
    end
    tick();
    check("t3_count", FIFO_COUNT, 4);
    check("t3_ovf", OVERFLOW, 1);
    mark = out_w.size();
    OUT_READY = 1'b1;
    repeat (6) tick();
    OUT_READY = 1'b0;
    check("t3_pulses", out_w.size() - mark, 4);
    if (out_w.size() >= mark + 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t3_word", out_w[mark+k], 9'h010 + k);
        check("t3_consec", out_c[mark+k], out_c[mark] + k);
      end
    end
    check("t3_ovf_sticky", OVERFLOW, 1);

    // SCLR with words buffered and OVERFLOW set
    for (int k = 0; k < 3; k++) begin
      k9 = 9'h030 + 9'(k);
      send_word(k9, 1'b0);
    end
    tick();
    check("t5_pre_count", FIFO_COUNT, 3);
    check("t5_pre_ovf", OVERFLOW, 1);
    SCLR = 1'b1;
    tick();
    SCLR = 1'b0;
    check("t5_count", FIFO_COUNT, 0);
    check("t5_ovf", OVERFLOW, 0);
    check("t5_we", WRITE_EN, 0);
    OUT_READY = 1'b1;
    tick();
    check("t5_we_after", WRITE_EN, 0);
    OUT_READY = 1'b0;

    // Full FIFO, pop coincides with the push of the next word
    for (int k = 0; k < 4; k++) begin
      k9 = 9'h020 + 9'(k);
      send_word(k9, 1'b0);
    end
    tick();
    check("t4_full", FIFO_COUNT, 4);
    mark = out_w.size();
    send_frame(9'h0AA, ^(9'h0AA), 1'b0, 1'b1, e1);
    #1;
    check("t4_count_same_edge", FIFO_COUNT, 4);
    repeat (7) tick();
    check("t4_ovf", OVERFLOW, 0);
    check("t4_pulses", out_w.size() - mark, 5);
    if (out_w.size() >= mark + 5) begin
      check("t4_first", out_w[mark], 9'h020);
      check("t4_last", out_w[mark+4], 9'h0AA);
    end

`ifdef INSTR_LOADER_PARITY_EN
    // Parity: good, bad, good
    mark = out_w.size();
    send_frame(9'h0F0, 1'b0, 1'b0, 1'b0, e1);
    send_frame(9'h0F1, 1'b0, 1'b0, 1'b0, e1);
    tick();
    check("t6_perr", PARITY_ERR, 1);
    check("t6_no_ovf", OVERFLOW, 0);
    send_frame(9'h003, 1'b0, 1'b0, 1'b0, e1);
    repeat (4) tick();
    check("t6_pulses", out_w.size() - mark, 2);
    if (out_w.size() >= mark + 2) begin
      check("t6_word0", out_w[mark], 9'h0F0);
      check("t6_word1", out_w[mark+1], 9'h003);
    end
    check("t6_perr_sticky", PARITY_ERR, 1);
`endif

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
